// File: rtl/ddr_axi_wr_master.sv
// Single-beat AXI4 write master fed by a packed {addr, data} stream, with an outstanding-B throttle.
// Optional statistics outputs (wr_cnt, err_cnt) are enabled by defining DDR_WR_STATS_EN.
module ddr_axi_wr_master #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH+ADDR_WIDTH-1:0] s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
  output logic [7:0]                       m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [1:0]                       m_axi_awburst,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [DATA_WIDTH-1:0]            m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]          m_axi_wstrb,
  output logic                             m_axi_wlast,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  input  logic [1:0]                       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  output logic                             busy,
  output logic                             err
`ifdef DDR_WR_STATS_EN
  ,
  output logic [31:0]                      wr_cnt,
  output logic [15:0]                      err_cnt
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = DATA_WIDTH / 8;

  logic                  hold_v;
  logic                  aw_p;
  logic                  w_p;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [CW-1:0]         out_cnt;
  logic                  fin;
  logic                  accept;
  logic                  b_dec;

  // The held beat may be replaced in the same cycle it finishes both channels.
  always_comb begin
    fin           = hold_v & (~aw_p | m_axi_awready) & (~w_p | m_axi_wready);
    s_axis_tready = ~rst & (~hold_v | fin) & (out_cnt < CW'(MAX_OUTSTANDING));
    accept        = s_axis_tvalid & s_axis_tready;
    b_dec         = m_axi_bvalid & (out_cnt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v  <= 1'b0;
      aw_p    <= 1'b0;
      w_p     <= 1'b0;
      out_cnt <= '0;
      err     <= 1'b0;
`ifdef DDR_WR_STATS_EN
      wr_cnt  <= '0;
      err_cnt <= '0;
`endif
    end else begin
      if (accept) begin
        addr_r <= s_axis_tdata[DATA_WIDTH +: ADDR_WIDTH];
        data_r <= s_axis_tdata[DATA_WIDTH-1:0];
        hold_v <= 1'b1;
        aw_p   <= 1'b1;
        w_p    <= 1'b1;
      end else begin
        if (aw_p && m_axi_awready) aw_p <= 1'b0;
        if (w_p && m_axi_wready)   w_p  <= 1'b0;
        if (fin)                   hold_v <= 1'b0;
      end

      if (accept && !b_dec)      out_cnt <= out_cnt + CW'(1);
      else if (!accept && b_dec) out_cnt <= out_cnt - CW'(1);

      if (m_axi_bvalid && (m_axi_bresp != 2'b00)) err <= 1'b1;

`ifdef DDR_WR_STATS_EN
      if (m_axi_bvalid) begin
        if (m_axi_bresp == 2'b00) wr_cnt <= wr_cnt + 32'd1;
        else if (err_cnt != '1)   err_cnt <= err_cnt + 16'd1;
      end
`endif
    end
  end

  assign m_axi_awaddr  = addr_r;
  assign m_axi_awlen   = '0;
  assign m_axi_awsize  = 3'($clog2(SW));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = aw_p;
  assign m_axi_wdata   = data_r;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = w_p;
  assign m_axi_bready  = 1'b1;
  assign busy          = hold_v | (out_cnt != '0);

endmodule

// File: tb/tb_ddr_axi_wr_master.sv
// Directed bench for ddr_axi_wr_master: AW/W scoreboard monitor plus inline checks of control behaviour.
module tb_ddr_axi_wr_master;
  localparam int DW   = 64;
  localparam int AW   = 32;
  localparam int MAXO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW+AW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b0;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic          busy;
  logic          err;
`ifdef DDR_WR_STATS_EN
  logic [31:0]   wr_cnt;
  logic [15:0]   err_cnt;
`endif

  // B channel: either driven directly by the sequence or returned 2 cycles after each AW.
  logic          b_man_v = 1'b0;
  logic [1:0]    b_man_r = 2'b00;
  logic          auto_b  = 1'b0;
  logic [2:0]    b_pipe  = '0;
  assign m_axi_bvalid = auto_b ? b_pipe[2] : b_man_v;
  assign m_axi_bresp  = auto_b ? 2'b00 : b_man_r;

  always #5 clk = ~clk;

  ddr_axi_wr_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .busy(busy), .err(err)
`ifdef DDR_WR_STATS_EN
    , .wr_cnt(wr_cnt), .err_cnt(err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] aw_q[$];
  logic [DW-1:0] w_q[$];
  int aw_total = 0, w_total = 0;
  int aw_run = 0, w_run = 0, aw_run_max = 0, w_run_max = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: accepted beats are queued, AW/W handshakes pop and compare in order.
  always @(negedge clk) begin
    if (rst) begin
      aw_q.delete();
      w_q.delete();
      aw_run = 0;
      w_run  = 0;
      b_pipe = '0;
    end else begin
      if (s_axis_tvalid && s_axis_tready) begin
        aw_q.push_back(s_axis_tdata[DW +: AW]);
        w_q.push_back(s_axis_tdata[DW-1:0]);
      end
      if (m_axi_awvalid && m_axi_awready) begin
        checks++;
        assert (aw_q.size() != 0) else begin
          errors++;
          $error("FAIL aw_unexpected: got awaddr %0h expected no AW", m_axi_awaddr);
        end
        if (aw_q.size() != 0) check("awaddr", 128'(m_axi_awaddr), 128'(aw_q.pop_front()));
        aw_total++;
        aw_run++;
        if (aw_run > aw_run_max) aw_run_max = aw_run;
      end else aw_run = 0;
      if (m_axi_wvalid && m_axi_wready) begin
        checks++;
        assert (w_q.size() != 0) else begin
          errors++;
          $error("FAIL w_unexpected: got wdata %0h expected no W", m_axi_wdata);
        end
        if (w_q.size() != 0) check("wdata", 128'(m_axi_wdata), 128'(w_q.pop_front()));
        w_total++;
        w_run++;
        if (w_run > w_run_max) w_run_max = w_run;
      end else w_run = 0;
      b_pipe = {b_pipe[1:0], m_axi_awvalid & m_axi_awready};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input int limit, output bit ok);
    ok = 1'b0;
    s_axis_tdata  = {a, d};
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic b_resp(input logic [1:0] r);
    tick();
    b_man_v = 1'b1;
    b_man_r = r;
    tick();
    b_man_v = 1'b0;
    b_man_r = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int aw_base, w_base;
    bit done;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", 128'(s_axis_tready), 128'(0));
    check("rst_awvalid", 128'(m_axi_awvalid), 128'(0));
    check("rst_wvalid", 128'(m_axi_wvalid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tready", 128'(s_axis_tready), 128'(1));
    tick();

    // Single write
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    send(32'h1000_0040, 64'hDEAD_BEEF_0123_4567, 10, ok);
    check("single_accept", 128'(ok), 128'(1));
    @(negedge clk);
    check("single_awvalid", 128'(m_axi_awvalid), 128'(1));
    check("single_wvalid", 128'(m_axi_wvalid), 128'(1));
    check("single_awaddr", 128'(m_axi_awaddr), 128'(32'h1000_0040));
    check("single_wdata", 128'(m_axi_wdata), 128'(64'hDEAD_BEEF_0123_4567));
    check("awlen", 128'(m_axi_awlen), 128'(0));
    check("awsize", 128'(m_axi_awsize), 128'(3));
    check("awburst", 128'(m_axi_awburst), 128'(1));
    check("wlast", 128'(m_axi_wlast), 128'(1));
    check("wstrb", 128'(m_axi_wstrb), 128'(8'hFF));
    check("bready", 128'(m_axi_bready), 128'(1));
    tick();
    @(negedge clk);
    check("single_aw_done", 128'(m_axi_awvalid), 128'(0));
    check("single_w_done", 128'(m_axi_wvalid), 128'(0));
    check("single_busy_wait_b", 128'(busy), 128'(1));
    b_resp(2'b00);
    @(negedge clk);
    check("single_busy_after_b", 128'(busy), 128'(0));

    // AW/W skew
    tick();
    m_axi_awready = 1'b0;
    send(32'h2000_0100, 64'h1111_2222_3333_4444, 10, ok);
    check("skew_accept", 128'(ok), 128'(1));
    @(negedge clk);
    check("skew_awvalid0", 128'(m_axi_awvalid), 128'(1));
    check("skew_wvalid0", 128'(m_axi_wvalid), 128'(1));
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("skew_wvalid_drop", 128'(m_axi_wvalid), 128'(0));
      check("skew_awvalid_hold", 128'(m_axi_awvalid), 128'(1));
      check("skew_awaddr_stable", 128'(m_axi_awaddr), 128'(32'h2000_0100));
      check("skew_tready_low", 128'(s_axis_tready), 128'(0));
    end
    tick();
    m_axi_awready = 1'b1;
    @(negedge clk);
    check("skew_tready_on_aw", 128'(s_axis_tready), 128'(1));
    check("skew_awvalid_hs", 128'(m_axi_awvalid), 128'(1));
    tick();
    @(negedge clk);
    check("skew_awvalid_done", 128'(m_axi_awvalid), 128'(0));
    b_resp(2'b00);
    @(negedge clk);
    check("skew_busy_done", 128'(busy), 128'(0));

    // Outstanding limit
    tick();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      send(32'h3000_0000 + 32'(8 * i), 64'(i), 20, ok);
      if (!ok) break;
      n++;
    end
    check("limit_accepted", 128'(n), 128'(MAXO));
    @(negedge clk);
    check("limit_tready_low", 128'(s_axis_tready), 128'(0));
    check("limit_busy", 128'(busy), 128'(1));
    b_resp(2'b00);
    send(32'h3000_0040, 64'd8, 20, ok);
    check("limit_one_more", 128'(ok), 128'(1));
    send(32'h3000_0048, 64'd9, 20, ok);
    check("limit_blocked_again", 128'(ok), 128'(0));
    for (int i = 0; i < MAXO; i++) b_resp(2'b00);
    @(negedge clk);
    check("limit_drained", 128'(busy), 128'(0));

    // Error response on the 3rd B
    tick();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(32'h5000_0000 + 32'(8 * i), 64'hA5A5_0000_0000_0000 | 64'(i), 20, ok);
      check("err_beat_accept", 128'(ok), 128'(1));
    end
    for (int k = 0; k < 8; k++) begin
      b_resp(k == 2 ? 2'b10 : 2'b00);
      @(negedge clk);
      check("err_sticky", 128'(err), 128'(k >= 2));
    end
`ifdef DDR_WR_STATS_EN
    check("stats_err_cnt", 128'(err_cnt), 128'(1));
    check("stats_wr_cnt", 128'(wr_cnt), 128'(7));
`endif

    // Reset mid-operation
    tick();
    m_axi_awready = 1'b0;
    send(32'h4000_0000, 64'h0BAD_F00D_0BAD_F00D, 10, ok);
    check("midrst_accept", 128'(ok), 128'(1));
    tick();
    @(negedge clk);
    check("midrst_aw_pending", 128'(m_axi_awvalid), 128'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_awvalid", 128'(m_axi_awvalid), 128'(0));
    check("midrst_wvalid", 128'(m_axi_wvalid), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_err", 128'(err), 128'(0));
    check("midrst_tready", 128'(s_axis_tready), 128'(1));

    // Throughput: 100 back-to-back beats, B two cycles after each AW
    tick();
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    auto_b  = 1'b1;
    aw_base = aw_total;
    w_base  = w_total;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      send(32'(8 * i), {$urandom, $urandom}, 5, ok);
      if (ok) n++;
    end
    check("tput_accepted", 128'(n), 128'(100));
    done = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check("tput_drained", 128'(done), 128'(1));
    check("tput_aw_total", 128'(aw_total - aw_base), 128'(100));
    check("tput_w_total", 128'(w_total - w_base), 128'(100));
    check("tput_aw_per_cycle", 128'(aw_run_max), 128'(100));
    check("tput_w_per_cycle", 128'(w_run_max), 128'(100));
    check("tput_aw_q_empty", 128'(aw_q.size()), 128'(0));
`ifdef DDR_WR_STATS_EN
    check("tput_wr_cnt", 128'(wr_cnt), 128'(100));
`endif
    auto_b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
